// File: rtl/ghash_seq.sv
// GHASH sequencing controller: pulls AAD/ciphertext blocks over a
// valid/ready stream, chains Y = (X ^ Y) * H on a digit-serial GF(2^128)
// multiplier, appends the {aad_len, txt_len} length block and returns S.

// One bit of the GF(2^128) right-shift multiply: conditional accumulate of V
// into Z, then V = V * x reduced by the GCM polynomial (bit-reflected form).
module ghash_bit_step (
  input  logic [127:0] z_i,
  input  logic [127:0] v_i,
  input  logic         x_bit,
  output logic [127:0] z_o,
  output logic [127:0] v_o
);
  localparam logic [127:0] R_POLY = {8'he1, 120'b0};

  assign z_o = x_bit ? (z_i ^ v_i) : z_i;
  assign v_o = (v_i >> 1) ^ (v_i[0] ? R_POLY : 128'b0);
endmodule

module ghash_seq #(
  parameter int DIGIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] h_key,
  input  logic [63:0]  aad_len,
  input  logic [63:0]  txt_len,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         busy,
  output logic         done,
  output logic [127:0] ghash_out
);
  localparam int        N      = 128 / DIGIT;
  localparam logic [7:0] K_LAST = 8'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MUL, S_LEN, S_DONE
  } state_t;

  // Per-job parameters captured on an accepted start
  typedef struct packed {
    logic [127:0] h;
    logic [63:0]  aad_len;
    logic [63:0]  txt_len;
  } job_t;

  state_t       state, state_nxt;
  job_t         job_q;
  logic [127:0] y_q;        // running GHASH accumulator
  logic [127:0] x_q;        // multiplier operand, consumed MSB first
  logic [127:0] z_q;        // partial product
  logic [127:0] v_q;        // H * x^k
  logic [7:0]   k_q;        // digit index within the current multiply
  logic [60:0]  remain_q;   // data blocks still to accept
  logic         len_pass_q; // current/last multiply is the length block
  logic [127:0] ghash_q;

  // Block count of the incoming job; AAD/ciphertext boundary is irrelevant,
  // only the total number of 128-bit blocks matters.
  logic [57:0] n_aad, n_txt;
  logic [60:0] total;

  assign n_aad = 58'(aad_len[63:7]) + 58'(|aad_len[6:0]);
  assign n_txt = 58'(txt_len[63:7]) + 58'(|txt_len[6:0]);
  assign total = 61'(n_aad) + 61'(n_txt);

  // Digit datapath: DIGIT chained single-bit steps per cycle
  logic [DIGIT:0][127:0] zc, vc;
  logic [127:0]          x_shift;

  assign zc[0] = z_q;
  assign vc[0] = v_q;

  generate
    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
      ghash_bit_step u_step (
        .z_i   (zc[i]),
        .v_i   (vc[i]),
        .x_bit (x_q[127-i]),
        .z_o   (zc[i+1]),
        .v_o   (vc[i+1])
      );
    end
    // Expose the next digit at the top of x_q for the following cycle
    if (DIGIT == 128) begin : g_xs_full
      assign x_shift = 128'b0;
    end else begin : g_xs_part
      assign x_shift = {x_q[127-DIGIT:0], {DIGIT{1'b0}}};
    end
  endgenerate

  logic mul_last;
  assign mul_last = (k_q == K_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (total != 61'd0) ? S_LOAD : S_LEN;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_MUL;
      end
      S_MUL: begin
        if (mul_last) begin
          if (remain_q != 61'd0) state_nxt = S_LOAD;
          else if (len_pass_q)   state_nxt = S_DONE;
          else                   state_nxt = S_LEN;
        end
      end
      S_LEN:  state_nxt = S_MUL;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: job capture, operand load, digit-serial multiply, result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      job_q      <= '0;
      y_q        <= '0;
      x_q        <= '0;
      z_q        <= '0;
      v_q        <= '0;
      k_q        <= '0;
      remain_q   <= '0;
      len_pass_q <= 1'b0;
      ghash_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            job_q      <= '{h: h_key, aad_len: aad_len, txt_len: txt_len};
            y_q        <= '0;
            remain_q   <= total;
            len_pass_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            x_q      <= in_data ^ y_q;
            remain_q <= remain_q - 61'd1;
            z_q      <= '0;
            v_q      <= job_q.h;
            k_q      <= '0;
          end
        end
        S_LEN: begin
          x_q        <= {job_q.aad_len, job_q.txt_len} ^ y_q;
          len_pass_q <= 1'b1;
          z_q        <= '0;
          v_q        <= job_q.h;
          k_q        <= '0;
        end
        S_MUL: begin
          z_q <= zc[DIGIT];
          v_q <= vc[DIGIT];
          x_q <= x_shift;
          k_q <= k_q + 8'd1;
          if (mul_last) begin
            y_q <= zc[DIGIT];
            // the length pass is always the final multiply of a job
            if (len_pass_q) ghash_q <= zc[DIGIT];
          end
        end
        default: ;
      endcase
    end
  end

  assign ghash_out = ghash_q;

endmodule

// File: tb/tb_ghash_seq.sv
// Directed bench for ghash_seq: three instances (DIGIT=1, 8, 128) share the
// stimulus; sel chooses which one receives start/in_valid and is observed.
module tb_ghash_seq;
  logic         clk = 1'b0;
  logic         rst_n, start, in_valid;
  logic [127:0] h_key, in_data;
  logic [63:0]  aad_len, txt_len;
  logic [1:0]   sel;

  logic [2:0]         st_g, iv_g, rdy, bsy, dn;
  logic [2:0][127:0]  gout;
  logic               rdy_s, bsy_s, dn_s;
  logic [127:0]       gout_s;

  int vecs = 0;
  int errs = 0;

  localparam logic [127:0] H2  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] C2  = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] S2  = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;

  logic [127:0] blk_q[$];

  always #5 clk = ~clk;

  assign st_g = {start && sel == 2'd2, start && sel == 2'd1, start && sel == 2'd0};
  assign iv_g = {in_valid && sel == 2'd2, in_valid && sel == 2'd1, in_valid && sel == 2'd0};

  always_comb begin
    rdy_s  = rdy[sel];
    bsy_s  = bsy[sel];
    dn_s   = dn[sel];
    gout_s = gout[sel];
  end

  ghash_seq #(.DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(st_g[0]), .h_key(h_key), .aad_len(aad_len),
    .txt_len(txt_len), .in_valid(iv_g[0]), .in_ready(rdy[0]), .in_data(in_data),
    .busy(bsy[0]), .done(dn[0]), .ghash_out(gout[0]));
  ghash_seq #(.DIGIT(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .start(st_g[1]), .h_key(h_key), .aad_len(aad_len),
    .txt_len(txt_len), .in_valid(iv_g[1]), .in_ready(rdy[1]), .in_data(in_data),
    .busy(bsy[1]), .done(dn[1]), .ghash_out(gout[1]));
  ghash_seq #(.DIGIT(128)) u_d128 (
    .clk(clk), .rst_n(rst_n), .start(st_g[2]), .h_key(h_key), .aad_len(aad_len),
    .txt_len(txt_len), .in_valid(iv_g[2]), .in_ready(rdy[2]), .in_data(in_data),
    .busy(bsy[2]), .done(dn[2]), .ghash_out(gout[2]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference multiply as polynomial product mod x^128+x^7+x^2+x+1
  function automatic logic [127:0] rev128(input logic [127:0] a);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = a[127-i];
    return r;
  endfunction

  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] h);
    logic [127:0] a, b;
    logic [254:0] c;
    a = rev128(x);
    b = rev128(h);
    c = '0;
    for (int i = 0; i < 128; i++) if (a[i]) c = c ^ (255'(b) << i);
    for (int j = 254; j >= 128; j--) begin
      if (c[j]) begin
        c[j] = 1'b0;
        c[j-128 +: 8] = c[j-128 +: 8] ^ 8'h87;
      end
    end
    return rev128(c[127:0]);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive the next pending block (or idle junk) after a clock edge
  task automatic present(input int idx, input bit rnd);
    if (idx < blk_q.size()) in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    else                    in_valid = 1'b0;
    in_data = in_valid ? blk_q[idx] : rnd128();
  endtask

  // Runs one job on DUT s. lat counts cycles inclusively from the start cycle
  // to the done cycle. rst_at != 0 pulses reset in that cycle and returns.
  task automatic run_job(input logic [1:0] s, input logic [127:0] h,
                         input logic [63:0] al, input logic [63:0] tl,
                         input bit rnd, input int rst_at,
                         output logic [127:0] res, output int lat,
                         output int hs, output int rdy_cyc, output logic bsy_done);
    int idx;
    bit got;
    @(posedge clk); #1;
    sel = s; h_key = h; aad_len = al; txt_len = tl; start = 1'b1;
    idx = 0; lat = 0; hs = 0; rdy_cyc = 0; got = 0; res = 'x; bsy_done = 1'b0;
    present(idx, rnd);
    while (lat < 3000) begin
      @(negedge clk);
      lat++;
      if (dn_s) begin
        got = 1; res = gout_s; bsy_done = bsy_s;
        break;
      end
      if (rdy_s) rdy_cyc++;
      if (rdy_s && in_valid) begin hs++; idx++; end
      if (rst_at != 0 && lat == rst_at) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0 | 1'b1; start = 1'b0; in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      // mid-job starts and changing key/lengths must all be ignored
      start   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      h_key   = rnd128();
      aad_len = {$urandom, $urandom};
      txt_len = {$urandom, $urandom};
      present(idx, rnd);
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk("job_done_seen", 128'(got), 128'd1);
  endtask

  initial begin
    logic [127:0] r, exp4;
    int lat, hs, rc, ndone;
    logic bd;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; sel = 2'd0;
    h_key = '0; in_data = '0; aad_len = '0; txt_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy",  128'(bsy[k]), 128'd0);
      chk("rst_done",  128'(dn[k]),  128'd0);
      chk("rst_ready", 128'(rdy[k]), 128'd0);
      chk("rst_gout",  gout[k],      128'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: zero-length job
    blk_q = {};
    run_job(2'd0, H2, 64'd0, 64'd0, 1'b0, 0, r, lat, hs, rc, bd);
    chk("t1_gout", r, 128'd0);
    chk("t1_lat", 128'(lat), 128'd131);
    chk("t1_ready_cycles", 128'(rc), 128'd0);
    chk("t1_busy_at_done", 128'(bd), 128'd1);
    @(negedge clk);
    chk("t1_busy_after", 128'(bsy_s), 128'd0);
    chk("t1_done_after", 128'(dn_s), 128'd0);

    // 2/3: one ciphertext block on each DIGIT
    blk_q = {C2};
    run_job(2'd0, H2, 64'd0, 64'd128, 1'b0, 0, r, lat, hs, rc, bd);
    chk("t2_d1_gout", r, S2);
    chk("t2_d1_lat", 128'(lat), 128'd260);
    chk("t2_d1_hs", 128'(hs), 128'd1);
    run_job(2'd1, H2, 64'd0, 64'd128, 1'b0, 0, r, lat, hs, rc, bd);
    chk("t3_d8_gout", r, S2);
    chk("t3_d8_lat", 128'(lat), 128'd36);
    run_job(2'd2, H2, 64'd0, 64'd128, 1'b0, 0, r, lat, hs, rc, bd);
    chk("t3_d128_gout", r, S2);
    chk("t3_d128_lat", 128'(lat), 128'd6);

    // 4: aad 160 bits (2nd AAD block zero-padded), txt 256 bits, one extra
    //    block offered beyond the total, random valid, random start pulses
    blk_q = {rnd128(), {$urandom, 96'b0}, rnd128(), rnd128(), rnd128()};
    exp4 = '0;
    for (int i = 0; i < 4; i++) exp4 = gf_mul(exp4 ^ blk_q[i], H2 ^ 128'h5a);
    exp4 = gf_mul(exp4 ^ {64'd160, 64'd256}, H2 ^ 128'h5a);
    run_job(2'd0, H2 ^ 128'h5a, 64'd160, 64'd256, 1'b1, 0, r, lat, hs, rc, bd);
    chk("t4_d1_gout", r, exp4);
    chk("t4_d1_hs", 128'(hs), 128'd4);
    run_job(2'd1, H2 ^ 128'h5a, 64'd160, 64'd256, 1'b1, 0, r, lat, hs, rc, bd);
    chk("t4_d8_gout", r, exp4);
    chk("t4_d8_hs", 128'(hs), 128'd4);

    // 6: back-to-back, start in the cycle right after done; Y must restart at 0
    blk_q = {C2};
    run_job(2'd1, H2, 64'd0, 64'd128, 1'b0, 0, r, lat, hs, rc, bd);
    chk("t6_b2b_gout", r, S2);
    chk("t6_b2b_lat", 128'(lat), 128'd36);

    // 5: reset in the middle of the second block's multiply
    blk_q = {C2, rnd128()};
    run_job(2'd0, H2, 64'd0, 64'd256, 1'b0, 200, r, lat, hs, rc, bd);
    @(negedge clk);
    chk("t5_busy", 128'(bsy_s), 128'd0);
    chk("t5_gout", gout_s, 128'd0);
    chk("t5_ready", 128'(rdy_s), 128'd0);
    chk("t5_done", 128'(dn_s), 128'd0);
    ndone = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dn_s) ndone++;
    end
    chk("t5_no_done", 128'(ndone), 128'd0);
    blk_q = {C2};
    run_job(2'd0, H2, 64'd0, 64'd128, 1'b0, 0, r, lat, hs, rc, bd);
    chk("t5_fresh_gout", r, S2);
    chk("t5_fresh_lat", 128'(lat), 128'd260);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
